// File: rtl/and2_mon_pkg.sv
// Shared types and constants for the and2 response monitor.
package and2_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam int LATENCY_MAX   = 8;
  localparam int CNT_W_DEFAULT = 8;
  localparam int FILL_W        = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/and2_mon_delay.sv
// Fixed-depth shift pipeline that delays {dut_reset, a&b} so it lines up
// with the and2 output it predicts.
module and2_mon_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // NOTE: the stages are cleared on reset so the first compares after reset
  // see a defined expected value instead of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/and2_resp_monitor.sv
// Response checker for the and2 block: compares c against delayed a&b.
// Optional first-failure capture is built when AND2_MON_FIRST_FAIL_EN is defined.
module and2_resp_monitor
  import and2_mon_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 2,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             dut_reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_got,
  output logic [WIDTH-1:0] first_fail_exp
);

  logic [WIDTH:0]   dly_out;
  logic [WIDTH-1:0] exp_val;
  logic             mismatch;

  and2_mon_delay #(.WIDTH(WIDTH + 1), .DEPTH(LATENCY)) u_delay (
    .clk  (clk),
    .rst  (reset),
    .din  ({dut_reset, a & b}),
    .dout (dly_out)
  );

  // A delayed dut_reset means the and2 output was being held at zero.
  assign exp_val  = dly_out[WIDTH] ? '0 : dly_out[WIDTH-1:0];
  assign mismatch = (c != exp_val);

  mon_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_FILL;
          fill_d      = FILL_W'(LATENCY);
          remaining_d = num_checks;
          err_cnt_d   = '0;
        end
      end
      ST_FILL: begin
        fill_d = fill_q - FILL_W'(1);
        if (fill_q == FILL_W'(1)) state_d = (remaining_q == '0) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_q == ST_FILL) || (state_q == ST_CHECK);
    done_d = (state_q == ST_DONE);
    pass_d = (state_q == ST_DONE) && (err_cnt_q == '0);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fill_q      <= '0;
      remaining_q <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;

`ifdef AND2_MON_FIRST_FAIL_EN
  logic             clear_run, do_cmp;
  logic [CNT_W-1:0] idx_q, idx_d, ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_got_q, ff_got_d, ff_exp_q, ff_exp_d;

  assign clear_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign do_cmp    = (state_q == ST_CHECK);

  // err_cnt never returns to zero within a run, so zero marks "no failure yet".
  always_comb begin
    idx_d    = idx_q;
    ff_idx_d = ff_idx_q;
    ff_got_d = ff_got_q;
    ff_exp_d = ff_exp_q;
    if (clear_run) begin
      idx_d    = '0;
      ff_idx_d = '0;
      ff_got_d = '0;
      ff_exp_d = '0;
    end else if (do_cmp) begin
      idx_d = idx_q + CNT_W'(1);
      if (mismatch && (err_cnt_q == '0)) begin
        ff_idx_d = idx_q;
        ff_got_d = c;
        ff_exp_d = exp_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      ff_idx_q <= '0;
      ff_got_q <= '0;
      ff_exp_q <= '0;
    end else begin
      idx_q    <= idx_d;
      ff_idx_q <= ff_idx_d;
      ff_got_q <= ff_got_d;
      ff_exp_q <= ff_exp_d;
    end
  end

  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;
  assign first_fail_exp = ff_exp_q;
`else
  assign first_fail_idx = '0;
  assign first_fail_got = '0;
  assign first_fail_exp = '0;
`endif

endmodule

// File: doc/and2_resp_monitor.md
Name: and2_resp_monitor

Overview:
- Synthesizable response checker that sits directly downstream of the and2 block.
- Consumes the and2 inputs (a, b, its reset) and its output c, then compares c against a delayed bitwise a&b.
- Counts mismatches and reports pass/fail after a programmed number of checks.
- Intended for on-fabric self-test alongside the and2 design.

Parameters:
- WIDTH, 2: bit width of a, b, c.
- LATENCY, 2: cycles from a/b (and dut_reset) sampled at a posedge to the matching c checked at a later posedge; legal range 1..8.
- CNT_W, 8: width of the error counter and the check counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset of this monitor.
- start  in  1  single-cycle pulse that begins a check run.
- num_checks  in  CNT_W  number of compare cycles per run, sampled on start.
- dut_reset  in  1  reset currently applied to the and2 block.
- a  in  WIDTH  and2 operand a.
- b  in  WIDTH  and2 operand b.
- c  in  WIDTH  and2 output under check.
- busy  out  1  high in FILL and CHECK.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_cnt==0.
- err_cnt  out  CNT_W  saturating mismatch count for the current run.
- first_fail_idx  out  CNT_W  compare index (0-based) of first mismatch.
- first_fail_got  out  WIDTH  c value at first mismatch.
- first_fail_exp  out  WIDTH  expected value at first mismatch.

Behaviour:
- Reset: asynchronous active-high; all outputs and registers clear to 0; state = IDLE. An assertion mid-run aborts the run, and no done pulse is produced.
- Expected-value pipeline:
  - Runs every cycle regardless of state.
  - Stage 0 captures {dut_reset, a&b}; after LATENCY stages it produces exp_rst and exp_val.
  - exp = exp_rst ? 0 : exp_val.
  - mismatch = (c != exp), evaluated at the posedge.
- State machine (states IDLE, FILL, CHECK, DONE):
  - IDLE: start → FILL. Latch num_checks into remaining; clear err_cnt and first_fail_*; load fill counter with LATENCY.
  - FILL: decrement fill counter each cycle; at 0 → CHECK, or → DONE if the latched num_checks == 0. Ensures only post-start inputs are checked.
  - CHECK: one compare per cycle.
    - On mismatch, err_cnt increments, saturating at 2^CNT_W-1.
    - On the first mismatch of the run, capture idx/got/exp.
    - Decrement remaining; the compare made when remaining==1 is the last one → DONE.
  - DONE: done=1 and pass=(err_cnt==0), held until the next start. Start in DONE behaves as start in IDLE (full clear, → FILL).
- start is ignored in FILL and CHECK.
- Output timing: busy, done and pass are registered and change one cycle after the state transition edge. err_cnt is visible the cycle after the compare.
- Simultaneous events: reset dominates start.
- Boundary cases:
  - A single-cycle dut_reset pulse only affects the one compare it aligns to.
  - num_checks = 2^CNT_W-1 is legal.

Optional Feature:
- Macro: AND2_MON_FIRST_FAIL_EN.
- Defined: first_fail_idx/got/exp capture logic and an index counter are present, with behaviour as above.
- Undefined: the three first_fail ports remain but are tied to 0, and no index counter is built. err_cnt, pass and done are unaffected.

Decomposition:
- Package and2_mon_pkg:
  - state encoding constants (IDLE=2'd0, FILL=2'd1, CHECK=2'd2, DONE=2'd3);
  - the LATENCY maximum (8);
  - the default CNT_W.
- Sub-module and2_mon_delay:
  - parameterized WIDTH+1-bit shift pipeline of depth LATENCY;
  - asynchronous reset to 0.

Test Plan:
- Correct DUT model, LATENCY=2, num_checks=8, a/b toggling as 00→11→11→00 patterns → done after 2+8 cycles, pass=1, err_cnt=0.
- c forced to 2'b11 at the 3rd compare while exp=2'b00 → err_cnt=1, pass=0, first_fail_idx=2, got=11, exp=00 (with the macro); without the macro the first_fail ports read 0.
- dut_reset held high for the whole run and c=00 → pass=1; c=01 with dut_reset high for 4 compares → err_cnt=4.
- CNT_W=4, c stuck mismatching, num_checks=15 → err_cnt saturates at 15, pass=0.
- reset asserted for 1 cycle mid-CHECK → outputs 0 asynchronously, state IDLE; a following start runs cleanly to pass=1.
- num_checks=0 → busy for LATENCY cycles, then done=1, pass=1; start pulses during FILL/CHECK have no effect on the run length.
